memsplit_xbar: RTL and testbench
================================

Name: memsplit_xbar

Overview:
- Parametrised MemSplit32 interconnect for the tile: NUM_M masters to NUM_S slaves, with per-slave round-robin arbitration and in-order read-response routing.
- Generalises the fixed 1:2 / 2:1 / 1:2 arbiter chain between the CPU data port, the host port (hpi), the external bus (xbus), data RAM and SFR into a single configurable block.
- Protocol matches MemSplit32:
  - Request handshake: req/ack.
  - Read response: single-cycle resp pulse with rdata.
  - Writes produce no response.

Parameters:
- NUM_M, 2, number of master ports (1..8).
- NUM_S, 2, number of slave ports (1..8).
- RESP_DEPTH, 4, maximum outstanding reads per slave; depth of each slave's master-ID FIFO (power of 2).
- S_BASE, {32'h0000_0000, 32'h8000_0000}, packed NUM_S x 32 slave base addresses.
- S_MASK, {32'h8000_0000, 32'h8000_0000}, packed NUM_S x 32 decode masks. Slave s hits when (addr & S_MASK[s]) == S_BASE[s].
- ERR_RDATA, 32'hDEAD_BEEF, read data returned for unmapped reads (optional feature only).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- m_req_i  in  NUM_M  master request.
- m_we_i  in  NUM_M  master write enable.
- m_addr_bi  in  NUM_M*32  master address.
- m_be_bi  in  NUM_M*4  master byte enables.
- m_wdata_bi  in  NUM_M*32  master write data.
- m_ack_o  out  NUM_M  request accepted.
- m_resp_o  out  NUM_M  read response valid.
- m_rdata_bo  out  NUM_M*32  read response data.
- s_req_o  out  NUM_S  slave request.
- s_we_o  out  NUM_S  slave write enable.
- s_addr_bo  out  NUM_S*32  slave address.
- s_be_bo  out  NUM_S*4  slave byte enables.
- s_wdata_bo  out  NUM_S*32  slave write data.
- s_ack_i  in  NUM_S  slave accepted request.
- s_resp_i  in  NUM_S  slave read response.
- s_rdata_bi  in  NUM_S*32  slave read data.
- err_o  out  1  sticky unmapped-access flag (0 when the optional feature is absent).

Behaviour:
- Reset (synchronous, rst_i=1 at a clock edge):
  - All *_o / *_bo outputs are 0.
  - Round-robin pointers point to master 0.
  - ID FIFOs are empty; outstanding counters are 0; locks are cleared; err_o is 0.
- Decode: combinational, per master. Lowest slave index wins on overlapping regions. A miss is handled per the Optional Feature.
- Eligibility: master m may request slave s only when all of the following hold:
  - m_req_i[m] is high and m decodes to s.
  - If it is a read, slave s's ID FIFO is not full.
  - If it is a read, m's outstanding-read count is below RESP_DEPTH.
  - If m has outstanding reads, s equals m's last read target. This keeps responses in order per master.
  - Otherwise the master stalls (no ack).
- Arbitration:
  - Each slave grants the first eligible master at or after its pointer.
  - The grant is combinational in the cycle a slave is unlocked.
  - While s_req_o[s]=1 and s_ack_i[s]=0, the grant is locked (registered) until ack. Address and data therefore cannot change mid-request.
  - On s_ack_i[s]: the pointer moves to granted+1 (mod NUM_M) and the lock clears.
- Request path:
  - s_req_o and the payload mirror the granted master with zero latency.
  - m_ack_o[m] = s_ack_i[s] & grant. Combinational, same cycle.
- Read tracking, on an acked read:
  - Push m into FIFO[s].
  - Increment m's counter and record s as m's last read target.
- Response path:
  - On s_resp_i[s], route to the master at the head of FIFO[s]: m_resp_o = 1 and m_rdata_bo = s_rdata_bi. Combinational, zero latency.
  - Pop FIFO[s] and decrement that master's counter.
  - Push and pop in the same cycle are both applied; the count is unchanged.
  - A response arriving with an empty FIFO is dropped. It asserts nothing, and simulation flags it with an assertion.
- Simultaneous responses: responses from different slaves always target different masters (guaranteed by the last-target rule). An increment and decrement of the same counter in one cycle leave it unchanged.
- Reset mid-transaction: in-flight state is discarded. Late slave responses after reset are dropped as empty-FIFO responses.

Optional Feature:
- Macro: MEMSPLIT_XBAR_ERRSLV_EN.
- Defined:
  - An internal error slave (index NUM_S) takes decode misses.
  - It acks in the same cycle, subject to the same last-target rule and its own RESP_DEPTH ID FIFO.
  - A read gets resp one cycle after ack with rdata = ERR_RDATA.
  - Any miss sets err_o, which is sticky until reset.
- Undefined: misses route to slave NUM_S-1 (default slave), and err_o is tied to 0.

Decomposition:
- memsplit_xbar_pkg holds:
  - localparams MID_W = $clog2(NUM_M) (min 1), SID_W, CNT_W = $clog2(RESP_DEPTH+1);
  - typedef struct memsplit_req_t {we, addr[31:0], be[3:0], wdata[31:0]};
  - a function for the round-robin pick.
- Sub-module memsplit_xbar_idfifo: synchronous FIFO of MID_W-bit IDs with depth RESP_DEPTH, push/pop/full/empty/head. Instantiated once per slave, plus once for the error slave.

Test Plan:
- Two masters read slave 0 (addr 0x100, 0x104) in the same cycle; slave acks both back to back → grants go m0 then m1; responses 0x11, 0x22 arrive at m0 then m1 respectively.
- Slave 1 holds ack low for 3 cycles while m0 waits and m1 raises req → grant stays on m0 with stable addr; m1 is served after ack.
- m0 reads slave 1 (0x8000_0000) then requests slave 0 before the response → slave 0 request is stalled until resp; issued the cycle after.
- Issue 4 reads to slave 0 with no responses (RESP_DEPTH=4), then a 5th → 5th not acked; a response pops one and the 5th is acked the next cycle.
- With S_MASK making 0x4000_0000 unmapped and MEMSPLIT_XBAR_ERRSLV_EN defined: read → ack same cycle, resp next cycle with 0xDEADBEEF, err_o=1. Without the macro: the read appears on slave 1.
- Assert rst_i while 2 reads are outstanding → all outputs 0 next cycle; a late s_resp_i produces no m_resp_o.

Source files
------------

// File: rtl/memsplit_xbar_pkg.sv
// Shared types and helpers for the memsplit_xbar interconnect.
// Optional internal error slave is enabled by MEMSPLIT_XBAR_ERRSLV_EN.
package memsplit_xbar_pkg;

    localparam int MAX_M = 8;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } memsplit_req_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Returns {found, index}: first set bit of elig at or after ptr, wrapping at n.
    function automatic logic [3:0] rr_pick(input logic [MAX_M-1:0] elig,
                                           input logic [2:0] ptr,
                                           input int n);
        logic [3:0] r;
        int         idx;
        r = '0;
        for (int i = MAX_M - 1; i >= 0; i--) begin
            if (i < n) begin
                idx = (int'(ptr) + i) % n;
                if (elig[3'(idx)]) r = {1'b1, 3'(idx)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/memsplit_xbar_idfifo.sv
// Master-ID FIFO recording the order of outstanding reads at one slave.
module memsplit_xbar_idfifo #(
    parameter int ID_W  = 1,
    parameter int DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [ID_W-1:0] id_i,
    output logic            full_o,
    output logic            empty_o,
    output logic [ID_W-1:0] head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count == CNT_W'(DEPTH));
    assign empty_o = (count == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= id_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/memsplit_xbar.sv
// NUM_M x NUM_S MemSplit32 crossbar: per-slave round-robin, in-order read responses.
// Define MEMSPLIT_XBAR_ERRSLV_EN to add an internal error slave for unmapped accesses.
module memsplit_xbar
    import memsplit_xbar_pkg::*;
#(
    parameter int                     NUM_M      = 2,
    parameter int                     NUM_S      = 2,
    parameter int                     RESP_DEPTH = 4,
    parameter logic [0:NUM_S-1][31:0] S_BASE     = {32'h0000_0000, 32'h8000_0000},
    parameter logic [0:NUM_S-1][31:0] S_MASK     = {32'h8000_0000, 32'h8000_0000},
    parameter logic [31:0]            ERR_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_M-1:0]     m_req_i,
    input  logic [NUM_M-1:0]     m_we_i,
    input  logic [NUM_M*32-1:0]  m_addr_bi,
    input  logic [NUM_M*4-1:0]   m_be_bi,
    input  logic [NUM_M*32-1:0]  m_wdata_bi,
    output logic [NUM_M-1:0]     m_ack_o,
    output logic [NUM_M-1:0]     m_resp_o,
    output logic [NUM_M*32-1:0]  m_rdata_bo,
    output logic [NUM_S-1:0]     s_req_o,
    output logic [NUM_S-1:0]     s_we_o,
    output logic [NUM_S*32-1:0]  s_addr_bo,
    output logic [NUM_S*4-1:0]   s_be_bo,
    output logic [NUM_S*32-1:0]  s_wdata_bo,
    input  logic [NUM_S-1:0]     s_ack_i,
    input  logic [NUM_S-1:0]     s_resp_i,
    input  logic [NUM_S*32-1:0]  s_rdata_bi,
    output logic                 err_o
);

`ifdef MEMSPLIT_XBAR_ERRSLV_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif
    localparam int NT       = NUM_S + ERR_EN;
    localparam int MISS_SLV = (ERR_EN != 0) ? NUM_S : NUM_S - 1;
    localparam int MID_W    = id_width(NUM_M);
    localparam int SID_W    = id_width(NT);
    localparam int CNT_W    = cnt_width(RESP_DEPTH);

    memsplit_req_t    m_pl     [NUM_M];
    logic [SID_W-1:0] dec_sel  [NUM_M];
    logic [CNT_W-1:0] cnt      [NUM_M];
    logic [SID_W-1:0] last_tgt [NUM_M];
    logic [SID_W-1:0] new_tgt  [NUM_M];
    logic [NUM_M-1:0] cnt_inc;
    logic [NUM_M-1:0] cnt_dec;

    logic [NUM_M-1:0] elig     [NT];
    logic [MID_W-1:0] rr_ptr   [NT];
    logic [MID_W-1:0] lock_id  [NT];
    logic [MID_W-1:0] gnt_id   [NT];
    logic [MID_W-1:0] f_head   [NT];
    logic [31:0]      rdata_int[NT];
    logic [NT-1:0]    lock;
    logic [NT-1:0]    gnt_vld;
    logic [NT-1:0]    ack_int;
    logic [NT-1:0]    resp_int;
    logic [NT-1:0]    acked;
    logic [NT-1:0]    acked_rd;
    logic [NT-1:0]    f_full;
    logic [NT-1:0]    f_empty;
    logic [NT-1:0]    f_pop;

`ifdef MEMSPLIT_XBAR_ERRSLV_EN
    logic [NUM_M-1:0] dec_miss;
    logic             err_q;
    logic             err_resp_q;
`else
    logic [31:0]      unused_err_rdata;
    assign unused_err_rdata = ERR_RDATA;
`endif

    for (genvar m = 0; m < NUM_M; m++) begin : g_mst
        assign m_pl[m].we    = m_we_i[m];
        assign m_pl[m].addr  = m_addr_bi[m*32 +: 32];
        assign m_pl[m].be    = m_be_bi[m*4 +: 4];
        assign m_pl[m].wdata = m_wdata_bi[m*32 +: 32];
    end

    // Scan downward so the lowest matching slave index wins.
    always_comb begin
        for (int m = 0; m < NUM_M; m++) begin
            dec_sel[m] = SID_W'(MISS_SLV);
`ifdef MEMSPLIT_XBAR_ERRSLV_EN
            dec_miss[m] = 1'b1;
`endif
            for (int s = NUM_S - 1; s >= 0; s--) begin
                if ((m_addr_bi[m*32 +: 32] & S_MASK[s]) == S_BASE[s]) begin
                    dec_sel[m] = SID_W'(s);
`ifdef MEMSPLIT_XBAR_ERRSLV_EN
                    dec_miss[m] = 1'b0;
`endif
                end
            end
        end
    end

    // A master with reads in flight may only talk to its last read target.
    always_comb begin
        for (int s = 0; s < NT; s++) begin
            for (int m = 0; m < NUM_M; m++) begin
                elig[s][m] = !rst_i && m_req_i[m] && (dec_sel[m] == SID_W'(s))
                    && (m_we_i[m] || (!f_full[s] && (cnt[m] < CNT_W'(RESP_DEPTH))))
                    && ((cnt[m] == '0) || (last_tgt[m] == SID_W'(s)));
            end
        end
    end

    always_comb begin
        logic [3:0] pick;
        for (int s = 0; s < NT; s++) begin
            pick = rr_pick(MAX_M'(elig[s]), 3'(rr_ptr[s]), NUM_M);
            if (lock[s]) begin
                gnt_vld[s] = !rst_i;
                gnt_id[s]  = lock_id[s];
            end else begin
                gnt_vld[s] = pick[3];
                gnt_id[s]  = MID_W'(pick[2:0]);
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NT; s++) begin
            acked[s]    = gnt_vld[s] && ack_int[s];
            acked_rd[s] = acked[s] && !m_pl[gnt_id[s]].we;
            f_pop[s]    = resp_int[s] && !f_empty[s] && !rst_i;
        end
    end

    for (genvar s = 0; s < NUM_S; s++) begin : g_slv
        assign ack_int[s]            = s_ack_i[s];
        assign resp_int[s]           = s_resp_i[s];
        assign rdata_int[s]          = s_rdata_bi[s*32 +: 32];
        assign s_req_o[s]            = gnt_vld[s];
        assign s_we_o[s]             = gnt_vld[s] && m_pl[gnt_id[s]].we;
        assign s_addr_bo[s*32 +: 32] = gnt_vld[s] ? m_pl[gnt_id[s]].addr  : '0;
        assign s_be_bo[s*4 +: 4]     = gnt_vld[s] ? m_pl[gnt_id[s]].be    : '0;
        assign s_wdata_bo[s*32 +: 32]= gnt_vld[s] ? m_pl[gnt_id[s]].wdata : '0;

        always_ff @(posedge clk_i) begin
            if (!rst_i) begin
                assert (!(s_resp_i[s] && f_empty[s]))
                    else $warning("memsplit_xbar: slave %0d response with no outstanding read dropped", s);
            end
        end
    end

`ifdef MEMSPLIT_XBAR_ERRSLV_EN
    assign ack_int[NUM_S]   = gnt_vld[NUM_S];
    assign resp_int[NUM_S]  = err_resp_q;
    assign rdata_int[NUM_S] = ERR_RDATA;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q      <= 1'b0;
            err_resp_q <= 1'b0;
        end else begin
            err_resp_q <= acked_rd[NUM_S];
            if (|(m_ack_o & dec_miss)) err_q <= 1'b1;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    for (genvar s = 0; s < NT; s++) begin : g_fifo
        memsplit_xbar_idfifo #(
            .ID_W  (MID_W),
            .DEPTH (RESP_DEPTH)
        ) u_idfifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (acked_rd[s]),
            .pop_i   (f_pop[s]),
            .id_i    (gnt_id[s]),
            .full_o  (f_full[s]),
            .empty_o (f_empty[s]),
            .head_o  (f_head[s])
        );
    end

    always_comb begin
        m_ack_o    = '0;
        m_resp_o   = '0;
        m_rdata_bo = '0;
        cnt_inc    = '0;
        cnt_dec    = '0;
        for (int m = 0; m < NUM_M; m++) new_tgt[m] = last_tgt[m];
        for (int s = 0; s < NT; s++) begin
            if (acked[s]) m_ack_o[gnt_id[s]] = 1'b1;
            if (acked_rd[s]) begin
                cnt_inc[gnt_id[s]] = 1'b1;
                new_tgt[gnt_id[s]] = SID_W'(s);
            end
            if (f_pop[s]) begin
                m_resp_o[f_head[s]]                   = 1'b1;
                m_rdata_bo[32*int'(f_head[s]) +: 32]  = rdata_int[s];
                cnt_dec[f_head[s]]                    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int m = 0; m < NUM_M; m++) begin
                cnt[m]      <= '0;
                last_tgt[m] <= '0;
            end
            for (int s = 0; s < NT; s++) begin
                rr_ptr[s]  <= '0;
                lock_id[s] <= '0;
            end
            lock <= '0;
        end else begin
            for (int m = 0; m < NUM_M; m++) begin
                cnt[m]      <= cnt[m] + CNT_W'(cnt_inc[m]) - CNT_W'(cnt_dec[m]);
                last_tgt[m] <= new_tgt[m];
            end
            // Hold a grant across slave wait states so the payload cannot switch.
            for (int s = 0; s < NT; s++) begin
                if (acked[s]) begin
                    rr_ptr[s] <= (int'(gnt_id[s]) == NUM_M - 1) ? '0 : gnt_id[s] + 1'b1;
                    lock[s]   <= 1'b0;
                end else if (gnt_vld[s]) begin
                    lock[s]    <= 1'b1;
                    lock_id[s] <= gnt_id[s];
                end
            end
        end
    end

endmodule

// File: tb/tb_memsplit_xbar.sv
// Directed testbench for memsplit_xbar (2 masters, 2 slaves, 0x4000_0000 unmapped).
module tb_memsplit_xbar;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  m_req_i, m_we_i;
    logic [63:0] m_addr_bi, m_wdata_bi;
    logic [7:0]  m_be_bi;
    logic [1:0]  m_ack_o, m_resp_o;
    logic [63:0] m_rdata_bo;
    logic [1:0]  s_req_o, s_we_o;
    logic [63:0] s_addr_bo, s_wdata_bo;
    logic [7:0]  s_be_bo;
    logic [1:0]  s_ack_i, s_resp_i;
    logic [63:0] s_rdata_bi;
    logic        err_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    memsplit_xbar #(
        .NUM_M      (2),
        .NUM_S      (2),
        .RESP_DEPTH (4),
        .S_BASE     ({32'h0000_0000, 32'h8000_0000}),
        .S_MASK     ({32'hC000_0000, 32'hC000_0000}),
        .ERR_RDATA  (32'hDEAD_BEEF)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .m_req_i    (m_req_i),
        .m_we_i     (m_we_i),
        .m_addr_bi  (m_addr_bi),
        .m_be_bi    (m_be_bi),
        .m_wdata_bi (m_wdata_bi),
        .m_ack_o    (m_ack_o),
        .m_resp_o   (m_resp_o),
        .m_rdata_bo (m_rdata_bo),
        .s_req_o    (s_req_o),
        .s_we_o     (s_we_o),
        .s_addr_bo  (s_addr_bo),
        .s_be_bo    (s_be_bo),
        .s_wdata_bo (s_wdata_bo),
        .s_ack_i    (s_ack_i),
        .s_resp_i   (s_resp_i),
        .s_rdata_bi (s_rdata_bi),
        .err_o      (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mst(input int m, input logic req, input logic we, input logic [31:0] addr);
        m_req_i[m]          = req;
        m_we_i[m]           = we;
        m_addr_bi[m*32 +: 32] = addr;
    endtask

    initial begin
        rst_i = 1'b1;
        m_req_i = '0; m_we_i = '0; m_addr_bi = '0; m_be_bi = 8'hFF; m_wdata_bi = '0;
        s_ack_i = '0; s_resp_i = '0; s_rdata_bi = '0;
        @(negedge clk_i);
        mst(0, 1'b1, 1'b0, 32'h0000_0040);
        s_ack_i = 2'b01;
        @(negedge clk_i); #1;
        chk("rst_sreq", 32'(s_req_o), 32'h0);
        chk("rst_mack", 32'(m_ack_o), 32'h0);
        chk("rst_saddr", s_addr_bo[31:0], 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);

        // write from m1: payload mirrored, no response tracked
        @(negedge clk_i);
        rst_i = 1'b0;
        mst(0, 1'b0, 1'b0, 32'h0);
        mst(1, 1'b1, 1'b1, 32'h0000_0040);
        m_be_bi[7:4] = 4'h3; m_wdata_bi[63:32] = 32'hCAFE_F00D;
        s_ack_i = 2'b01; #1;
        chk("wr_sreq", 32'(s_req_o), 32'h1);
        chk("wr_we", 32'(s_we_o), 32'h1);
        chk("wr_be", 32'(s_be_bo[3:0]), 32'h3);
        chk("wr_wdata", s_wdata_bo[31:0], 32'hCAFE_F00D);
        chk("wr_ack", 32'(m_ack_o), 32'h2);

        // two masters read slave 0 together
        @(negedge clk_i);
        m_be_bi = 8'hFF;
        mst(0, 1'b1, 1'b0, 32'h0000_0100);
        mst(1, 1'b1, 1'b0, 32'h0000_0104); #1;
        chk("t1_addr_m0", s_addr_bo[31:0], 32'h0000_0100);
        chk("t1_ack_m0", 32'(m_ack_o), 32'h1);
        @(negedge clk_i);
        mst(0, 1'b0, 1'b0, 32'h0); #1;
        chk("t1_addr_m1", s_addr_bo[31:0], 32'h0000_0104);
        chk("t1_ack_m1", 32'(m_ack_o), 32'h2);
        @(negedge clk_i);
        mst(1, 1'b0, 1'b0, 32'h0);
        s_ack_i = 2'b00; s_resp_i = 2'b01; s_rdata_bi[31:0] = 32'h11; #1;
        chk("t1_resp_m0", 32'(m_resp_o), 32'h1);
        chk("t1_rdata_m0", m_rdata_bo[31:0], 32'h11);
        @(negedge clk_i);
        s_rdata_bi[31:0] = 32'h22; #1;
        chk("t1_resp_m1", 32'(m_resp_o), 32'h2);
        chk("t1_rdata_m1", m_rdata_bo[63:32], 32'h22);

        // slave 1 wait states hold the grant on m0
        @(negedge clk_i);
        s_resp_i = 2'b00;
        mst(0, 1'b1, 1'b0, 32'h8000_0010); #1;
        chk("t2_sreq", 32'(s_req_o), 32'h2);
        chk("t2_noack", 32'(m_ack_o), 32'h0);
        @(negedge clk_i);
        mst(1, 1'b1, 1'b0, 32'h8000_0020); #1;
        chk("t2_hold1", s_addr_bo[63:32], 32'h8000_0010);
        chk("t2_noack1", 32'(m_ack_o), 32'h0);
        @(negedge clk_i); #1;
        chk("t2_hold2", s_addr_bo[63:32], 32'h8000_0010);
        @(negedge clk_i);
        s_ack_i = 2'b10; #1;
        chk("t2_ack_m0", 32'(m_ack_o), 32'h1);
        @(negedge clk_i);
        mst(0, 1'b0, 1'b0, 32'h0); #1;
        chk("t2_addr_m1", s_addr_bo[63:32], 32'h8000_0020);
        chk("t2_ack_m1", 32'(m_ack_o), 32'h2);
        @(negedge clk_i);
        mst(1, 1'b0, 1'b0, 32'h0);
        s_ack_i = 2'b00; s_resp_i = 2'b10; s_rdata_bi[63:32] = 32'hA1; #1;
        chk("t2_resp_m0", 32'(m_resp_o), 32'h1);
        chk("t2_rdata_m0", m_rdata_bo[31:0], 32'hA1);
        @(negedge clk_i);
        s_rdata_bi[63:32] = 32'hA2; #1;
        chk("t2_resp_m1", 32'(m_resp_o), 32'h2);
        chk("t2_rdata_m1", m_rdata_bo[63:32], 32'hA2);

        // switching target with a read in flight stalls until the response
        @(negedge clk_i);
        s_resp_i = 2'b00;
        mst(0, 1'b1, 1'b0, 32'h8000_0100); s_ack_i = 2'b10; #1;
        chk("t3_ack_s1", 32'(m_ack_o), 32'h1);
        @(negedge clk_i);
        mst(0, 1'b1, 1'b0, 32'h0000_0200); s_ack_i = 2'b01; #1;
        chk("t3_stall_req", 32'(s_req_o), 32'h0);
        chk("t3_stall_ack", 32'(m_ack_o), 32'h0);
        @(negedge clk_i);
        s_resp_i = 2'b10; s_rdata_bi[63:32] = 32'h33; #1;
        chk("t3_resp", 32'(m_resp_o), 32'h1);
        chk("t3_rdata", m_rdata_bo[31:0], 32'h33);
        chk("t3_still_stall", 32'(s_req_o), 32'h0);
        @(negedge clk_i);
        s_resp_i = 2'b00; #1;
        chk("t3_issue_req", 32'(s_req_o), 32'h1);
        chk("t3_issue_addr", s_addr_bo[31:0], 32'h0000_0200);
        chk("t3_issue_ack", 32'(m_ack_o), 32'h1);
        @(negedge clk_i);
        mst(0, 1'b0, 1'b0, 32'h0); s_ack_i = 2'b00;
        s_resp_i = 2'b01; s_rdata_bi[31:0] = 32'h44; #1;
        chk("t3_resp2", 32'(m_resp_o), 32'h1);

        // fill slave 0 to RESP_DEPTH outstanding reads
        @(negedge clk_i);
        s_resp_i = 2'b00; s_ack_i = 2'b01;
        for (int k = 0; k < 4; k++) begin
            mst(0, 1'b1, 1'b0, 32'h0000_0300 + 32'(4 * k)); #1;
            chk("t4_fill_ack", 32'(m_ack_o), 32'h1);
            @(negedge clk_i);
        end
        mst(0, 1'b1, 1'b0, 32'h0000_0310); #1;
        chk("t4_full_ack", 32'(m_ack_o), 32'h0);
        chk("t4_full_req", 32'(s_req_o), 32'h0);
        @(negedge clk_i);
        s_resp_i = 2'b01; s_rdata_bi[31:0] = 32'h55; #1;
        chk("t4_pop_resp", 32'(m_resp_o), 32'h1);
        chk("t4_pop_noack", 32'(m_ack_o), 32'h0);
        @(negedge clk_i);
        s_resp_i = 2'b00; #1;
        chk("t4_fifth_ack", 32'(m_ack_o), 32'h1);
        @(negedge clk_i);
        mst(0, 1'b0, 1'b0, 32'h0); s_ack_i = 2'b00; s_resp_i = 2'b01;
        for (int k = 0; k < 4; k++) begin
            s_rdata_bi[31:0] = 32'h60 + 32'(k); #1;
            chk("t4_drain_resp", 32'(m_resp_o), 32'h1);
            chk("t4_drain_rdata", m_rdata_bo[31:0], 32'h60 + 32'(k));
            @(negedge clk_i);
        end
        s_resp_i = 2'b00;

        // unmapped read
        mst(1, 1'b1, 1'b0, 32'h4000_0000);
`ifdef MEMSPLIT_XBAR_ERRSLV_EN
        #1;
        chk("t5_err_sreq", 32'(s_req_o), 32'h0);
        chk("t5_err_ack", 32'(m_ack_o), 32'h2);
        @(negedge clk_i);
        mst(1, 1'b0, 1'b0, 32'h0); #1;
        chk("t5_err_resp", 32'(m_resp_o), 32'h2);
        chk("t5_err_rdata", m_rdata_bo[63:32], 32'hDEAD_BEEF);
        chk("t5_err_flag", 32'(err_o), 32'h1);
`else
        s_ack_i = 2'b10; #1;
        chk("t5_dflt_sreq", 32'(s_req_o), 32'h2);
        chk("t5_dflt_addr", s_addr_bo[63:32], 32'h4000_0000);
        chk("t5_dflt_ack", 32'(m_ack_o), 32'h2);
        @(negedge clk_i);
        mst(1, 1'b0, 1'b0, 32'h0); s_ack_i = 2'b00;
        s_resp_i = 2'b10; s_rdata_bi[63:32] = 32'h77; #1;
        chk("t5_dflt_resp", 32'(m_resp_o), 32'h2);
        chk("t5_dflt_rdata", m_rdata_bo[63:32], 32'h77);
        chk("t5_dflt_err", 32'(err_o), 32'h0);
`endif

        // reset with two reads outstanding
        @(negedge clk_i);
        s_resp_i = 2'b00;
        mst(0, 1'b1, 1'b0, 32'h0000_0500);
        mst(1, 1'b1, 1'b0, 32'h8000_0500);
        s_ack_i = 2'b11; #1;
        chk("t6_ack_both", 32'(m_ack_o), 32'h3);
        @(negedge clk_i);
        mst(0, 1'b0, 1'b0, 32'h0); mst(1, 1'b0, 1'b0, 32'h0);
        s_ack_i = 2'b00; rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0; s_resp_i = 2'b01; s_rdata_bi[31:0] = 32'h99; #1;
        chk("t6_late_resp0", 32'(m_resp_o), 32'h0);
        chk("t6_rdata_zero", m_rdata_bo[31:0], 32'h0);
        chk("t6_sreq_zero", 32'(s_req_o), 32'h0);
        chk("t6_err_zero", 32'(err_o), 32'h0);
        @(negedge clk_i);
        s_resp_i = 2'b10; #1;
        chk("t6_late_resp1", 32'(m_resp_o), 32'h0);
        @(negedge clk_i);
        s_resp_i = 2'b00;
        mst(0, 1'b1, 1'b0, 32'h8000_0600); s_ack_i = 2'b10; #1;
        chk("t6_fresh_ack", 32'(m_ack_o), 32'h1);
        @(negedge clk_i);
        mst(0, 1'b0, 1'b0, 32'h0); s_ack_i = 2'b00;
        @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
